// File: rtl/rsa_batch_ctrl_if.sv
// Host-load, core-control and result signals of the RSA batch sequencer.
// The master modport is the sequencer side; slave is the host/core side.
interface rsa_batch_ctrl_if #(
  parameter int unsigned DATA_W = 5,
  parameter int unsigned ADDR_W = 3
);
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              start;
  logic [DATA_W-1:0] pt;
  logic              wren;
  logic [ADDR_W-1:0] wraddr;
  logic              rden;
  logic [ADDR_W-1:0] rdaddr;
  logic              ds;
  logic [ADDR_W-1:0] rdaddr1;
  logic              e_d;
  logic              d_d;
  logic [DATA_W-1:0] cipher_text;
  logic [DATA_W-1:0] pt_org;
  logic              ct_valid;
  logic [DATA_W-1:0] ct_data;
  logic [ADDR_W-1:0] ct_idx;
  logic [ADDR_W:0]   err_cnt;
  logic              timeout;
  logic              busy;
  logic              done;

  modport master (
    input  ld_valid, ld_data, start, e_d, d_d, cipher_text, pt_org,
    output ld_ready, pt, wren, wraddr, rden, rdaddr, ds, rdaddr1,
           ct_valid, ct_data, ct_idx, err_cnt, timeout, busy, done
  );

  modport slave (
    output ld_valid, ld_data, start, e_d, d_d, cipher_text, pt_org,
    input  ld_ready, pt, wren, wraddr, rden, rdaddr, ds, rdaddr1,
           ct_valid, ct_data, ct_idx, err_cnt, timeout, busy, done
  );
endinterface

// File: rtl/rsa_batch_ctrl.sv
// Batch sequencer for the rsa core: buffers plaintexts, writes them to the core,
// then encrypts/decrypts each entry, streams ciphertexts and counts mismatches.
module rsa_batch_ctrl #(
  parameter int unsigned DATA_W  = 5,
  parameter int unsigned ADDR_W  = 3,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TMO_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  rsa_batch_ctrl_if.master  bus
);
  localparam int unsigned CW       = ADDR_W + 1;
  localparam logic [7:0]  TMO_LAST = 8'(TMO_CYC - 1);

  typedef enum logic [2:0] {IDLE, WR, ENC, DEC, REL, FIN} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     count, idx, idx_inc;
  logic [7:0]        wcnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              live, rdy, last, wait_end;
  logic              ld_take, st_take, tmo_hit;
  logic              ct_valid_q, timeout_q;
  logic [DATA_W-1:0] ct_data_q;
  logic [ADDR_W-1:0] ct_idx_q;
  logic [CW-1:0]     err_cnt_q;

  // live keeps ld_ready low while reset is held and rises on the first edge after release
  assign rdy      = live && (state == IDLE) && (count < CW'(DEPTH));
  assign idx_inc  = idx + 1'b1;
  assign last     = (idx_inc == count);
  assign wait_end = (wcnt == TMO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n     = state;
    ld_take     = 1'b0;
    st_take     = 1'b0;
    tmo_hit     = 1'b0;
    bus.ld_ready = rdy;
    bus.wren    = (state == WR);
    bus.pt      = (state == WR) ? mem[idx[ADDR_W-1:0]] : '0;
    bus.wraddr  = (state == WR) ? idx[ADDR_W-1:0] : '0;
    bus.rden    = (state == ENC) || (state == DEC);
    bus.rdaddr  = bus.rden ? idx[ADDR_W-1:0] : '0;
    bus.ds      = (state == DEC);
    bus.rdaddr1 = bus.ds ? idx[ADDR_W-1:0] : '0;
    bus.busy    = (state != IDLE) && (state != FIN);
    bus.done    = (state == FIN);
    case (state)
      IDLE: begin
        // a load offered alongside start wins; start is dropped that cycle
        if (bus.ld_valid && rdy) begin
          ld_take = 1'b1;
        end else if (bus.start && live) begin
          st_take = 1'b1;
          state_n = (count == '0) ? FIN : WR;
        end
      end
      WR:  if (last) state_n = ENC;
      ENC: begin
        if (bus.e_d)     state_n = DEC;
        else if (wait_end) begin tmo_hit = 1'b1; state_n = FIN; end
      end
      DEC: begin
        if (bus.d_d)     state_n = REL;
        else if (wait_end) begin tmo_hit = 1'b1; state_n = FIN; end
      end
      REL: begin
        if (!bus.e_d && !bus.d_d) state_n = last ? FIN : ENC;
        else if (wait_end) begin tmo_hit = 1'b1; state_n = FIN; end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ld_take) mem[count[ADDR_W-1:0]] <= bus.ld_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      live       <= 1'b0;
      count      <= '0;
      idx        <= '0;
      wcnt       <= '0;
      ct_valid_q <= 1'b0;
      ct_data_q  <= '0;
      ct_idx_q   <= '0;
      err_cnt_q  <= '0;
      timeout_q  <= 1'b0;
    end else begin
      live       <= 1'b1;
      ct_valid_q <= 1'b0;
      wcnt       <= (state_n != state) ? '0 : wcnt + 1'b1;
      if (tmo_hit) timeout_q <= 1'b1;
      case (state)
        IDLE: begin
          if (ld_take) count <= count + 1'b1;
          if (st_take) begin
            err_cnt_q <= '0;
            timeout_q <= 1'b0;
            idx       <= '0;
          end
        end
        WR:  idx <= last ? '0 : idx_inc;
        ENC: if (bus.e_d) begin
          ct_data_q  <= bus.cipher_text;
          ct_idx_q   <= idx[ADDR_W-1:0];
          ct_valid_q <= 1'b1;
        end
        DEC: if (bus.d_d && (bus.pt_org != mem[idx[ADDR_W-1:0]]) && (err_cnt_q < CW'(DEPTH)))
          err_cnt_q <= err_cnt_q + 1'b1;
        REL: if (!bus.e_d && !bus.d_d) idx <= idx_inc;
        FIN: begin
          count <= '0;
          idx   <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.ct_valid = ct_valid_q;
  assign bus.ct_data  = ct_data_q;
  assign bus.ct_idx   = ct_idx_q;
  assign bus.err_cnt  = err_cnt_q;
  assign bus.timeout  = timeout_q;
endmodule

// File: tb/tb_rsa_batch_ctrl.sv
// Bench for rsa_batch_ctrl with a behavioural rsa core (n=33, e=3) and ciphertext scoreboard.
module tb_rsa_batch_ctrl;
  localparam int DATA_W = 5;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;
  localparam int E_LAT  = 3;
  localparam int D_LAT  = 2;

  typedef struct packed {logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d;} ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rsa_batch_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  rsa_batch_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .TMO_CYC(255)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int nt = 0;
  int nf = 0;

  // core model
  logic [DATA_W-1:0] ram [DEPTH] = '{default: '0};
  logic [DEPTH-1:0]  corrupt = '0;
  bit                hang_en = 1'b0;
  logic [ADDR_W-1:0] hang_idx = '0;
  int ec, dc;

  function automatic logic [DATA_W-1:0] cube(input logic [DATA_W-1:0] p);
    int unsigned v;
    v = (int'(p) * int'(p) * int'(p)) % 33;
    return v[DATA_W-1:0];
  endfunction

  always @(posedge clk) if (bus.wren) ram[bus.wraddr] <= bus.pt;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.e_d <= 1'b0; bus.d_d <= 1'b0; ec <= 0; dc <= 0;
    end else begin
      if (bus.rden) begin
        if (ec == E_LAT) bus.e_d <= 1'b1; else ec <= ec + 1;
      end else begin
        ec <= 0; bus.e_d <= 1'b0;
      end
      if (bus.ds && !(hang_en && bus.rdaddr1 == hang_idx)) begin
        if (dc == D_LAT) bus.d_d <= 1'b1; else dc <= dc + 1;
      end else begin
        dc <= 0; bus.d_d <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.cipher_text = cube(ram[bus.rdaddr]);
    bus.pt_org      = ram[bus.rdaddr1] ^ (corrupt[bus.rdaddr1] ? 5'd1 : 5'd0);
  end

  // monitor
  ent_t wr_q[$], ct_q[$], exp_wr[$], exp_ct[$];
  int cyc = 0, wr_first = 0, wr_last = 0, rden_cyc = 0, ds_run = 0, ds_last = 0;

  always @(negedge clk) begin
    cyc++;
    if (bus.wren) begin
      wr_q.push_back({bus.wraddr, bus.pt});
      if (wr_q.size() == 1) wr_first = cyc;
      wr_last = cyc;
    end
    if (bus.ct_valid) ct_q.push_back({bus.ct_idx, bus.ct_data});
    if (bus.rden) rden_cyc++;
    if (bus.ds) ds_run++;
    else if (ds_run != 0) begin ds_last = ds_run; ds_run = 0; end
  end

  task automatic clear_mon();
    wr_q.delete(); ct_q.delete(); exp_wr.delete(); exp_ct.delete();
    rden_cyc = 0; ds_run = 0; ds_last = 0;
  endtask

  task automatic load(input logic [DATA_W-1:0] v);
    @(negedge clk); bus.ld_valid = 1'b1; bus.ld_data = v;
    @(negedge clk); bus.ld_valid = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk); #1;
      if (bus.done) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    #2;
    nt++;
    if ({bus.ld_ready, bus.wren, bus.rden, bus.ds, bus.ct_valid, bus.busy, bus.done,
         bus.timeout, bus.err_cnt, bus.pt, bus.wraddr} !== '0) begin
      nf++; $display("FAIL reset_outputs: got ready=%b wren=%b rden=%b ds=%b busy=%b done=%b want all 0",
                     bus.ld_ready, bus.wren, bus.rden, bus.ds, bus.busy, bus.done);
    end
    @(negedge clk); rst = 1'b1; #1;
    nt++;
    if (bus.ld_ready !== 1'b0) begin nf++; $display("FAIL ready_before_edge: got %b want 0", bus.ld_ready); end
    @(posedge clk); #1;
    nt++;
    if (bus.ld_ready !== 1'b1) begin nf++; $display("FAIL ready_after_release: got %b want 1", bus.ld_ready); end
  endtask

  task automatic test_single();
    bit seen;
    clear_mon();
    load(5'd5);
    exp_ct.push_back({3'd0, 5'd26});
    do_start();
    wait_done(200, seen);
    nt++; if (!seen) begin nf++; $display("FAIL single_done: got none want done pulse"); end
    nt++;
    if (wr_q.size() != 1 || wr_q[0] !== ent_t'({3'd0, 5'd5})) begin
      nf++; $display("FAIL single_write: got %0d writes want 1 at addr0/pt5", wr_q.size());
    end
    nt++;
    if (ct_q.size() != 1 || ct_q[0] !== exp_ct[0]) begin
      nf++; $display("FAIL single_ct: got %0d pulses want 1 with idx0/ct26", ct_q.size());
    end
    nt++; if (bus.err_cnt !== '0) begin nf++; $display("FAIL single_err: got %0d want 0", bus.err_cnt); end
    nt++; if (bus.busy !== 1'b0) begin nf++; $display("FAIL single_busy: got %b want 0", bus.busy); end
    @(negedge clk); #1;
    nt++; if (bus.done !== 1'b0) begin nf++; $display("FAIL single_done_width: got %b want 0", bus.done); end
  endtask

  task automatic test_full();
    bit seen;
    ent_t e;
    clear_mon();
    for (int i = 0; i < DEPTH; i++) begin
      load(5'(i));
      exp_wr.push_back({3'(i), 5'(i)});
      exp_ct.push_back({3'(i), cube(5'(i))});
    end
    #1;
    nt++; if (bus.ld_ready !== 1'b0) begin nf++; $display("FAIL full_ready: got %b want 0", bus.ld_ready); end
    load(5'd31);
    do_start(); #1;
    nt++;
    if (bus.busy !== 1'b1 || bus.ld_ready !== 1'b0) begin
      nf++; $display("FAIL full_busy: got busy=%b ready=%b want busy=1 ready=0", bus.busy, bus.ld_ready);
    end
    wait_done(2000, seen);
    nt++; if (!seen) begin nf++; $display("FAIL full_done: got none want done pulse"); end
    nt++;
    if (wr_q.size() != DEPTH || wr_last - wr_first != DEPTH - 1) begin
      nf++; $display("FAIL full_wr_burst: got %0d writes over %0d cycles want 8 over 8", wr_q.size(), wr_last - wr_first + 1);
    end
    while (exp_wr.size() != 0 && wr_q.size() != 0) begin
      e = exp_wr.pop_front();
      nt++; if (wr_q[0] !== e) begin nf++; $display("FAIL full_wr: got %h want %h", wr_q[0], e); end
      void'(wr_q.pop_front());
    end
    nt++; if (ct_q.size() != DEPTH) begin nf++; $display("FAIL full_ct_count: got %0d want 8", ct_q.size()); end
    while (exp_ct.size() != 0 && ct_q.size() != 0) begin
      e = exp_ct.pop_front();
      nt++; if (ct_q[0] !== e) begin nf++; $display("FAIL full_ct: got %h want %h", ct_q[0], e); end
      void'(ct_q.pop_front());
    end
    nt++; if (bus.err_cnt !== '0) begin nf++; $display("FAIL full_err: got %0d want 0", bus.err_cnt); end
  endtask

  task automatic test_mismatch();
    bit seen;
    ent_t e;
    logic [DATA_W-1:0] v;
    clear_mon();
    corrupt = 8'b0010_0100;
    for (int i = 0; i < DEPTH; i++) begin
      v = 5'($urandom_range(0, 31));
      load(v);
      exp_ct.push_back({3'(i), cube(v)});
    end
    do_start();
    wait_done(2000, seen);
    nt++; if (!seen) begin nf++; $display("FAIL mism_done: got none want done pulse"); end
    nt++; if (bus.err_cnt !== 4'd2) begin nf++; $display("FAIL mism_err: got %0d want 2", bus.err_cnt); end
    nt++; if (ct_q.size() != DEPTH) begin nf++; $display("FAIL mism_ct_count: got %0d want 8", ct_q.size()); end
    while (exp_ct.size() != 0 && ct_q.size() != 0) begin
      e = exp_ct.pop_front();
      nt++; if (ct_q[0] !== e) begin nf++; $display("FAIL mism_ct: got %h want %h", ct_q[0], e); end
      void'(ct_q.pop_front());
    end
    corrupt = '0;
  endtask

  task automatic test_timeout();
    bit seen;
    ent_t e;
    clear_mon();
    hang_en = 1'b1; hang_idx = 3'd1;
    load(5'd7); load(5'd9); load(5'd11);
    exp_ct.push_back({3'd0, cube(5'd7)});
    exp_ct.push_back({3'd1, cube(5'd9)});
    do_start();
    wait_done(2000, seen);
    nt++; if (!seen) begin nf++; $display("FAIL tmo_done: got none want done pulse"); end
    nt++; if (bus.timeout !== 1'b1) begin nf++; $display("FAIL tmo_flag: got %b want 1", bus.timeout); end
    nt++;
    if (bus.ds !== 1'b0 || bus.rden !== 1'b0) begin
      nf++; $display("FAIL tmo_strobes: got ds=%b rden=%b want 0 0", bus.ds, bus.rden);
    end
    nt++; if (ds_last != 255) begin nf++; $display("FAIL tmo_wait_len: got %0d want 255", ds_last); end
    nt++; if (ct_q.size() != 2) begin nf++; $display("FAIL tmo_ct_count: got %0d want 2", ct_q.size()); end
    while (exp_ct.size() != 0 && ct_q.size() != 0) begin
      e = exp_ct.pop_front();
      nt++; if (ct_q[0] !== e) begin nf++; $display("FAIL tmo_ct: got %h want %h", ct_q[0], e); end
      void'(ct_q.pop_front());
    end
    hang_en = 1'b0;
    clear_mon();
    load(5'd3);
    do_start(); #1;
    nt++; if (bus.timeout !== 1'b0) begin nf++; $display("FAIL tmo_clear: got %b want 0", bus.timeout); end
    wait_done(200, seen);
    nt++;
    if (!seen || ct_q.size() != 1 || ct_q[0] !== ent_t'({3'd0, cube(5'd3)})) begin
      nf++; $display("FAIL tmo_recover: got done=%b ct_count=%0d want done=1 ct_count=1", seen, ct_q.size());
    end
  endtask

  task automatic test_empty();
    clear_mon();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0; #1;
    nt++; if (bus.done !== 1'b1) begin nf++; $display("FAIL empty_done: got %b want 1", bus.done); end
    repeat (3) @(negedge clk);
    #1;
    nt++;
    if (wr_q.size() != 0 || rden_cyc != 0 || ds_last != 0 || ds_run != 0) begin
      nf++; $display("FAIL empty_activity: got wr=%0d rden=%0d ds=%0d want 0 0 0", wr_q.size(), rden_cyc, ds_last + ds_run);
    end
    nt++; if (bus.err_cnt !== '0) begin nf++; $display("FAIL empty_err: got %0d want 0", bus.err_cnt); end
  endtask

  task automatic test_reset_mid();
    int n;
    int dones;
    clear_mon();
    hang_en = 1'b1; hang_idx = 3'd0;
    load(5'd4); load(5'd6);
    do_start();
    n = 0;
    while (bus.ds !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    nt++; if (bus.ds !== 1'b1) begin nf++; $display("FAIL rmid_reach_dec: got ds=%b want 1", bus.ds); end
    repeat (3) @(negedge clk);
    #2 rst = 1'b0; #1;
    nt++;
    if ({bus.ds, bus.rden, bus.busy, bus.ct_valid} !== 4'b0) begin
      nf++; $display("FAIL rmid_outputs: got ds=%b rden=%b busy=%b ctv=%b want 0", bus.ds, bus.rden, bus.busy, bus.ct_valid);
    end
    dones = 0;
    for (int i = 0; i < 3; i++) begin @(negedge clk); if (bus.done) dones++; end
    hang_en = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin @(negedge clk); if (bus.done) dones++; end
    nt++; if (dones != 0) begin nf++; $display("FAIL rmid_no_done: got %0d pulses want 0", dones); end
    nt++; if (bus.ld_ready !== 1'b1) begin nf++; $display("FAIL rmid_ready: got %b want 1", bus.ld_ready); end
    clear_mon();
    bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0; #1;
    nt++;
    if (bus.done !== 1'b1) begin nf++; $display("FAIL rmid_count_zero: got done=%b want 1", bus.done); end
    @(negedge clk); #1;
    nt++; if (wr_q.size() != 0) begin nf++; $display("FAIL rmid_no_writes: got %0d want 0", wr_q.size()); end
  endtask

  initial begin
    bus.ld_valid = 1'b0;
    bus.ld_data  = '0;
    bus.start    = 1'b0;
    test_reset();
    test_single();
    test_full();
    test_mismatch();
    test_timeout();
    test_empty();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", nt, nf);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/rsa_batch_ctrl.md
Name: rsa_batch_ctrl

Overview:
Batch sequencer directly upstream of the rsa core; it is the only block that drives the core's RAM-write, encrypt-read and decrypt-trigger inputs. It buffers up to DEPTH 5-bit plaintexts from a host and writes them into the core's plaintext RAM. For each entry it then runs encryption and decryption, streams out the ciphertext, and checks that the recovered plaintext equals the original. It reports the mismatch count, a timeout flag and a done pulse.

Parameters:
DATA_W, 5, plaintext/ciphertext width (matches core)
ADDR_W, 3, core RAM address width
DEPTH, 8, buffer entries (= 2**ADDR_W)
TMO_CYC, 255, max cycles waiting on e_d or d_d before abort (counter width 8)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset (rst=0 resets)
ld_valid  in  1  host offers plaintext
ld_data  in  DATA_W  plaintext value
ld_ready  out  1  buffer accepts; high only in IDLE with count<DEPTH
start  in  1  begin batch (sampled in IDLE only)
pt  out  DATA_W  core plaintext write data
wren  out  1  core RAM0 write enable
wraddr  out  ADDR_W  core RAM0 write address
rden  out  1  core encrypt strobe (RAM0 read)
rdaddr  out  ADDR_W  core RAM0 read address
ds  out  1  core decrypt strobe (RAM1 read)
rdaddr1  out  ADDR_W  core RAM1 read address
e_d  in  1  core encryption-done level
d_d  in  1  core decryption-done level
cipher_text  in  DATA_W  core ciphertext
pt_org  in  DATA_W  core recovered plaintext
ct_valid  out  1  one-cycle pulse: ciphertext available
ct_data  out  DATA_W  ciphertext of entry ct_idx
ct_idx  out  ADDR_W  entry index
err_cnt  out  ADDR_W+1  decrypt mismatches this batch
timeout  out  1  sticky abort flag, cleared on next accepted start
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse at batch end

Behaviour:
- Reset (async, rst=0): all outputs 0, count=0, idx=0, state IDLE; ld_ready rises the first cycle after release. Reset mid-batch abandons it; no done pulse.
- Load: ld_valid&ld_ready stores ld_data at buf[count], count++. When count=DEPTH, ld_ready=0. When ld_valid and start are both high in the same cycle, the load is taken and start is ignored.
- States: IDLE -> WR -> ENC -> DEC -> REL -> (ENC next idx | FIN) -> IDLE.
- IDLE: start=1 -> busy=1, err_cnt=0, timeout=0, idx=0. If count=0, go straight to FIN; otherwise go to WR.
- WR: one cycle per entry: wren=1, wraddr=idx, pt=buf[idx]; idx++. After count cycles: idx=0, go to ENC. Writes are back-to-back, with no gaps.
- ENC: hold rden=1, rdaddr=idx until e_d=1. On that cycle, register cipher_text into ct_data, ct_idx=idx, pulse ct_valid, go to DEC. rden remains high through DEC.
- DEC: hold ds=1, rdaddr1=idx until d_d=1. On that cycle, compare pt_org with buf[idx]; if unequal, err_cnt++ (saturating at DEPTH). Go to REL.
- REL: drop rden and ds; wait until e_d=0 and d_d=0. Then idx++. If idx=count go to FIN, else go to ENC.
- Timeout: a wait counter is cleared on entering ENC, DEC and REL. When it reaches TMO_CYC without the awaited condition: timeout=1, rden=ds=0, go to FIN. Remaining entries are skipped.
- FIN: done=1 for one cycle, busy=0, count=0 (buffer emptied), go to IDLE.
- start while busy: ignored. ld_valid while busy: ld_ready=0, not accepted.
- Address wrap: idx never exceeds count-1; DEPTH=8 uses all addresses 0..7.
- Latency per entry, with the core done-flags taking E and D cycles: ENC E+1, DEC D+1, REL ≥1 cycle.

Test Plan:
- Single entry: load 5, start -> one wren cycle at wraddr=0/pt=5; rden until e_d; ct_valid with ct_data=cipher_text (26 for n=33,e=3); ds until d_d; pt_org=5 -> err_cnt=0; done pulse, busy falls.
- Full batch: load 0..7, start -> 8 consecutive wren cycles at addr 0..7; 8 ct_valid pulses with ct_idx 0..7 in order; err_cnt=0; a 9th ld_valid before start is refused (ld_ready=0).
- Mismatch: core model corrupts pt_org for idx 2 and 5 -> err_cnt=2 at done; ciphertexts still streamed for all entries.
- Timeout: core never raises d_d on idx 1 -> after 255 wait cycles timeout=1, ds=0, done pulse; only ct_idx 0 and 1 emitted; next start clears timeout.
- Empty start: count=0, start -> done one cycle later, no wren/rden/ds activity, err_cnt=0.
- Reset mid-DEC: rst=0 while ds=1 -> ds, rden, busy, ct_valid go to 0 immediately; no done pulse; after release, ld_ready=1 and count=0.
